// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter between
// NUM_REQ requesters. Each requester owns a one-entry holding slot; the
// FSM frames the winning slot as {id, payload}, strobes tx_send and
// follows tx_busy until the byte has left or the UART never started.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// S_IDLE       | no byte in flight; grants the next full slot round-robin
// S_SEND       | framed byte on tx_data, tx_send high for this one cycle
// S_WAIT_START | waiting for tx_busy to rise, bounded by START_TIMEOUT
// S_WAIT_DONE  | UART shifting the byte; leaves when tx_busy falls

module uart_tx_arbiter #(
    parameter int NUM_REQ       = 2,
    parameter int ID_BITS       = $clog2(NUM_REQ),
    parameter int PAYLOAD_BITS  = 8 - ID_BITS,
    parameter int START_TIMEOUT = 16
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*PAYLOAD_BITS-1:0] req_data,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic [7:0]                      tx_data,
    output logic                            tx_send,
    input  logic                            tx_busy,
    output logic [ID_BITS-1:0]              grant_id,
    output logic                            busy,
    output logic                            sent,
    output logic                            timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_START,
        S_WAIT_DONE
    } state_t;

    // Down-counter starts at START_TIMEOUT-1 so terminal count 0 lands
    // exactly START_TIMEOUT cycles after the SEND cycle.
    localparam logic [7:0]         CNT_INIT  = 8'(START_TIMEOUT - 1);
    localparam logic [ID_BITS-1:0] LAST_INIT = ID_BITS'(NUM_REQ - 1);

    state_t                  state_q;
    state_t                  state_d;
    logic [NUM_REQ-1:0]      full_q;
    logic [PAYLOAD_BITS-1:0] slot_data_q [NUM_REQ];
    logic [ID_BITS-1:0]      last_q;
    logic [ID_BITS-1:0]      win_id;
    logic                    win_found;
    logic                    grant_en;
    logic                    cnt_load;
    logic [7:0]              cnt_q;
    logic [7:0]              tx_data_q;
    logic [ID_BITS-1:0]      grant_q;

    assign req_ready = ~full_q;
    assign tx_data   = tx_data_q;
    assign grant_id  = grant_q;
    assign busy      = (state_q != S_IDLE);

    // Round-robin pick: first full slot above last, then wrap to the lowest.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!win_found && full_q[i] && (i > int'(last_q))) begin
                win_found = 1'b1;
                win_id    = ID_BITS'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!win_found && full_q[i] && (i <= int'(last_q))) begin
                win_found = 1'b1;
                win_id    = ID_BITS'(i);
            end
        end
    end

    // Holding slots: capture on valid&&ready, empty on grant (never both).
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            full_q <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                slot_data_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant_en && (win_id == ID_BITS'(i))) begin
                    full_q[i] <= 1'b0;
                end else if (req_valid[i] && !full_q[i]) begin
                    full_q[i]      <= 1'b1;
                    slot_data_q[i] <= req_data[i*PAYLOAD_BITS +: PAYLOAD_BITS];
                end
            end
        end
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and strobe decode; all strobes are state-derived so an
    // asynchronous reset clears them immediately.
    always_comb begin
        state_d     = state_q;
        grant_en    = 1'b0;
        cnt_load    = 1'b0;
        tx_send     = 1'b0;
        sent        = 1'b0;
        timeout_err = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    grant_en = 1'b1;
                    state_d  = S_SEND;
                end
            end
            S_SEND: begin
                tx_send  = 1'b1;
                cnt_load = 1'b1;
                state_d  = S_WAIT_START;
            end
            S_WAIT_START: begin
                if (tx_busy) begin
                    state_d = S_WAIT_DONE;
                end else if (cnt_q == 8'd0) begin
                    timeout_err = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    sent    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Start timeout down-counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= CNT_INIT;
        end else if (cnt_load) begin
            cnt_q <= CNT_INIT;
        end else if ((state_q == S_WAIT_START) && (cnt_q != 8'd0)) begin
            cnt_q <= cnt_q - 8'd1;
        end
    end

    // Frame register and grant bookkeeping, held until the next grant.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tx_data_q <= '0;
            grant_q   <= '0;
            last_q    <= LAST_INIT;
        end else if (grant_en) begin
            tx_data_q <= 8'({win_id, slot_data_q[win_id]});
            grant_q   <= win_id;
            last_q    <= win_id;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with default parameters
// (2 requesters, 1-bit id, 7-bit payload, START_TIMEOUT 16).

module tb_uart_tx_arbiter;

    logic        clock;
    logic        reset_n;
    logic [1:0]  req_valid;
    logic [13:0] req_data;
    logic [1:0]  req_ready;
    logic [7:0]  tx_data;
    logic        tx_send;
    logic        tx_busy;
    logic [0:0]  grant_id;
    logic        busy;
    logic        sent;
    logic        timeout_err;

    int n_checks = 0;
    int n_pass   = 0;

    uart_tx_arbiter dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .tx_data     (tx_data),
        .tx_send     (tx_send),
        .tx_busy     (tx_busy),
        .grant_id    (grant_id),
        .busy        (busy),
        .sent        (sent),
        .timeout_err (timeout_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_data(input logic [6:0] d0, input logic [6:0] d1);
        req_data = {d1, d0};
    endtask

    // Poll for tx_send, bounded; leaves time at the SEND cycle.
    task automatic wait_send(input string tag);
        bit seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (tx_send) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check_eq(tag, 32'(seen), 32'd1);
    endtask

    // Called in the SEND cycle; tx_busy high for n cycles (n >= 2).
    task automatic serve(input string tag, input int n);
        tx_busy = 1'b1;
        repeat (n) tick();
        tx_busy = 1'b0;
        #1;
        check_eq({tag, "_sent"}, 32'(sent), 32'd1);
        tick();
        check_eq({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    logic [7:0] exp_frame [5];
    logic [0:0] exp_id    [5];
    int         early_to;

    initial begin
        reset_n   = 1'b0;
        req_valid = 2'b00;
        req_data  = '0;
        tx_busy   = 1'b0;
        repeat (3) tick();

        check_eq("rst_tx_data", 32'(tx_data), 32'h00);
        check_eq("rst_tx_send", 32'(tx_send), 32'd0);
        check_eq("rst_grant",   32'(grant_id), 32'd0);
        check_eq("rst_busy",    32'(busy), 32'd0);
        check_eq("rst_sent",    32'(sent), 32'd0);
        check_eq("rst_timeout", 32'(timeout_err), 32'd0);
        check_eq("rst_ready",   32'(req_ready), 32'h3);
        reset_n = 1'b1;
        tick();

        // Single byte from requester 1: {1, 7'h2A} = 8'hAA.
        req_valid = 2'b10;
        set_data(7'h00, 7'h2A);
        tick();
        req_valid = 2'b00;
        #1;
        check_eq("t1_ready_full", 32'(req_ready), 32'h1);
        check_eq("t1_no_send_yet", 32'(tx_send), 32'd0);
        tick();
        check_eq("t1_send", 32'(tx_send), 32'd1);
        check_eq("t1_data", 32'(tx_data), 32'hAA);
        check_eq("t1_grant", 32'(grant_id), 32'd1);
        check_eq("t1_ready_refill", 32'(req_ready), 32'h3);
        tx_busy = 1'b1;
        tick();
        check_eq("t1_send_once", 32'(tx_send), 32'd0);
        repeat (9) tick();
        check_eq("t1_busy_mid", 32'(busy), 32'd1);
        check_eq("t1_no_sent_mid", 32'(sent), 32'd0);
        tx_busy = 1'b0;
        #1;
        check_eq("t1_sent", 32'(sent), 32'd1);
        tick();
        check_eq("t1_sent_pulse", 32'(sent), 32'd0);
        check_eq("t1_idle", 32'(busy), 32'd0);
        check_eq("t1_data_hold", 32'(tx_data), 32'hAA);

        // Fairness: both held valid; order 0,1,0,1 then the refilled slot 0.
        exp_frame = '{8'h11, 8'hA2, 8'h11, 8'hA2, 8'h11};
        exp_id    = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        req_valid = 2'b11;
        set_data(7'h11, 7'h22);
        for (int g = 0; g < 5; g++) begin
            wait_send($sformatf("t2_wait%0d", g));
            check_eq($sformatf("t2_grant%0d", g), 32'(grant_id), 32'(exp_id[g]));
            check_eq($sformatf("t2_data%0d", g), 32'(tx_data), 32'(exp_frame[g]));
            if (g == 3) req_valid = 2'b00;
            serve($sformatf("t2_b%0d", g), 3);
        end
        check_eq("t2_drained", 32'(req_ready), 32'h3);

        // Backpressure: slot 0 filled while requester 1 is on the wire.
        req_valid = 2'b10;
        set_data(7'h00, 7'h55);
        tick();
        req_valid = 2'b00;
        wait_send("t3_wait_a");
        check_eq("t3_data_a", 32'(tx_data), 32'hD5);
        tx_busy   = 1'b1;
        req_valid = 2'b01;
        set_data(7'h33, 7'h00);
        tick();
        set_data(7'h44, 7'h00);
        #1;
        check_eq("t3_ready_low", 32'(req_ready), 32'h2);
        tick();
        tick();
        check_eq("t3_still_full", 32'(req_ready), 32'h2);
        req_valid = 2'b00;
        tx_busy   = 1'b0;
        #1;
        check_eq("t3_sent_a", 32'(sent), 32'd1);
        tick();
        wait_send("t3_wait_b");
        check_eq("t3_data_b", 32'(tx_data), 32'h33);
        check_eq("t3_grant_b", 32'(grant_id), 32'd0);
        serve("t3_b", 2);

        // Timeout: both loaded, requester 1 wins (last=0) and UART never starts.
        req_valid = 2'b11;
        set_data(7'h0F, 7'h70);
        tick();
        req_valid = 2'b00;
        wait_send("t4_wait");
        check_eq("t4_data", 32'(tx_data), 32'hF0);
        early_to = 0;
        for (int c = 1; c < 16; c++) begin
            tick();
            if (timeout_err || sent) early_to++;
        end
        check_eq("t4_no_early", 32'(early_to), 32'd0);
        tick();
        check_eq("t4_timeout", 32'(timeout_err), 32'd1);
        check_eq("t4_no_sent", 32'(sent), 32'd0);
        tick();
        check_eq("t4_timeout_pulse", 32'(timeout_err), 32'd0);
        check_eq("t4_idle", 32'(busy), 32'd0);
        tick();
        check_eq("t4_next_send", 32'(tx_send), 32'd1);
        check_eq("t4_next_data", 32'(tx_data), 32'h0F);
        serve("t4_next", 2);

        // Reset in WAIT_DONE with requester 1 holding a byte.
        req_valid = 2'b01;
        set_data(7'h01, 7'h00);
        tick();
        req_valid = 2'b00;
        wait_send("t5_wait_a");
        tx_busy = 1'b1;
        tick();
        tick();
        req_valid = 2'b10;
        set_data(7'h00, 7'h02);
        tick();
        req_valid = 2'b00;
        #1;
        check_eq("t5_pre_busy", 32'(busy), 32'd1);
        check_eq("t5_pre_ready", 32'(req_ready), 32'h1);
        reset_n = 1'b0;
        #1;
        check_eq("t5_busy", 32'(busy), 32'd0);
        check_eq("t5_send", 32'(tx_send), 32'd0);
        check_eq("t5_ready", 32'(req_ready), 32'h3);
        check_eq("t5_data", 32'(tx_data), 32'h00);
        tick();
        check_eq("t5_no_sent", 32'(sent), 32'd0);
        reset_n   = 1'b1;
        tx_busy   = 1'b0;
        req_valid = 2'b11;
        set_data(7'h0A, 7'h0B);
        tick();
        req_valid = 2'b00;
        wait_send("t5_wait_b");
        check_eq("t5_first_grant", 32'(grant_id), 32'd0);
        check_eq("t5_first_data", 32'(tx_data), 32'h0A);
        serve("t5_b", 2);
        wait_send("t5_wait_c");
        check_eq("t5_second_grant", 32'(grant_id), 32'd1);
        check_eq("t5_second_data", 32'(tx_data), 32'h8B);
        serve("t5_c", 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
